// File: rtl/regfile_master.sv
// regfile_master: initiator for the four-phase re/rack, we/wack regfile protocol.
// Optional writeback first, then reads of rs and rt returned over valid/ready.
module regfile_master #(
  parameter int REG_SZ      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_rs,
  input  logic [4:0]        cmd_rt,
  input  logic              cmd_wen,
  input  logic [4:0]        cmd_rd,
  input  logic [REG_SZ-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [REG_SZ-1:0] rsp_rs_val,
  output logic [REG_SZ-1:0] rsp_rt_val,
  output logic              rsp_err,
  output logic [4:0]        r_idx,
  output logic [4:0]        w_idx,
  output logic              re,
  output logic              we,
  output logic [REG_SZ-1:0] din,
  input  logic              rack,
  input  logic              wack,
  input  logic [REG_SZ-1:0] dout
);

  typedef enum logic [2:0] {
    IDLE, W_REQ, W_REL, R1_REQ, R1_REL, R2_REQ, R2_REL, RESP
  } state_t;

  // The FSM register is the last synchronizer stage, so the
  // dedicated chain is one flop shorter than SYNC_STAGES.
  localparam int SD = (SYNC_STAGES > 1) ? SYNC_STAGES - 1 : 1;

  logic [SD-1:0] rack_q, wack_q;
  logic          rack_s, wack_s;
  state_t        state, acc_tgt, wr_tgt;
  logic [4:0]    rs_q, rt_q;
  logic [7:0]    tcnt;
  logic          busy, done, tmo;

  function automatic state_t rd_next(input logic [4:0] s,
                                     input logic [4:0] t);
    if (s != 5'd0) return R1_REQ;
    if (t != 5'd0) return R2_REQ;
    return RESP;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rack_q <= '0;
      wack_q <= '0;
    end else begin
      rack_q[0] <= rack;
      wack_q[0] <= wack;
      for (int i = 1; i < SD; i++) begin
        rack_q[i] <= rack_q[i-1];
        wack_q[i] <= wack_q[i-1];
      end
    end
  end

  assign rack_s = rack_q[SD-1];
  assign wack_s = wack_q[SD-1];

  always_comb begin
    busy    = 1'b1;
    done    = 1'b0;
    acc_tgt = cmd_wen ? W_REQ : rd_next(cmd_rs, cmd_rt);
    wr_tgt  = rd_next(rs_q, rt_q);
    tmo     = (tcnt == 8'(TIMEOUT - 1));
    unique case (state)
      W_REQ:          done = wack_s;
      W_REL:          done = ~wack_s;
      R1_REQ, R2_REQ: done = rack_s;
      R1_REL, R2_REL: done = ~rack_s;
      default:        busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      re         <= 1'b0;
      we         <= 1'b0;
      r_idx      <= '0;
      w_idx      <= '0;
      din        <= '0;
      rsp_rs_val <= '0;
      rsp_rt_val <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      tcnt       <= '0;
    end else begin
      tcnt <= '0;
      if (busy && !done) begin
        if (tmo) begin
          state     <= RESP;
          re        <= 1'b0;
          we        <= 1'b0;
          rsp_err   <= 1'b1;
          rsp_valid <= 1'b1;
        end else begin
          tcnt <= tcnt + 8'd1;
        end
      end else begin
        unique case (state)
          IDLE: begin
            cmd_ready <= ~rack_s & ~wack_s;
            if (cmd_valid && cmd_ready) begin
              cmd_ready  <= 1'b0;
              state      <= acc_tgt;
              rs_q       <= cmd_rs;
              rt_q       <= cmd_rt;
              rsp_rs_val <= '0;
              rsp_rt_val <= '0;
              rsp_valid  <= (acc_tgt == RESP);
              if (cmd_wen) begin
                we    <= 1'b1;
                w_idx <= cmd_rd;
                din   <= cmd_wdata;
              end else if (acc_tgt != RESP) begin
                re    <= 1'b1;
                r_idx <= (acc_tgt == R2_REQ) ? cmd_rt : cmd_rs;
              end
            end
          end
          W_REQ: begin
            we    <= 1'b0;
            state <= W_REL;
          end
          W_REL: begin
            state     <= wr_tgt;
            rsp_valid <= (wr_tgt == RESP);
            if (wr_tgt != RESP) begin
              re    <= 1'b1;
              r_idx <= (wr_tgt == R2_REQ) ? rt_q : rs_q;
            end
          end
          R1_REQ: begin
            re         <= 1'b0;
            rsp_rs_val <= dout;
            state      <= R1_REL;
          end
          R1_REL: begin
            if (rt_q != 5'd0) begin
              re    <= 1'b1;
              r_idx <= rt_q;
              state <= R2_REQ;
            end else begin
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end
          R2_REQ: begin
            re         <= 1'b0;
            rsp_rt_val <= dout;
            state      <= R2_REL;
          end
          R2_REL: begin
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
          RESP: begin
            if (rsp_ready) begin
              rsp_valid <= 1'b0;
              rsp_err   <= 1'b0;
              state     <= IDLE;
              cmd_ready <= ~rack_s & ~wack_s;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_regfile_master.sv
// tb_regfile_master: directed and random commands against a regfile model
// with configurable ack delay; expectations come from an array model.
module tb_regfile_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_wen, rsp_valid, rsp_ready, rsp_err;
  logic [4:0]  cmd_rs, cmd_rt, cmd_rd, r_idx, w_idx;
  logic [31:0] cmd_wdata, rsp_rs_val, rsp_rt_val, din, dout;
  logic        re, we, rack, wack;

  regfile_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_wen(cmd_wen),
    .cmd_rd(cmd_rd), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rs_val(rsp_rs_val), .rsp_rt_val(rsp_rt_val), .rsp_err(rsp_err),
    .r_idx(r_idx), .w_idx(w_idx), .re(re), .we(we), .din(din),
    .rack(rack), .wack(wack), .dout(dout)
  );

  always #5 clk = ~clk;

  logic [31:0] mem   [32];
  logic [31:0] model [32];
  int          re_cnt = 0;
  int          we_cnt = 0;
  logic [4:0]  we_idx_seen;
  logic [31:0] we_din_seen;
  bit          ack_en = 1'b1;
  int          rdly = 0;
  int          checks = 0;
  int          errors = 0;

  assign dout = mem[r_idx];

  always @(posedge we) begin
    if (w_idx != 5'd0) mem[w_idx] <= din;
    we_cnt      <= we_cnt + 1;
    we_idx_seen <= w_idx;
    we_din_seen <= din;
  end

  always @(posedge re) re_cnt <= re_cnt + 1;

  initial begin
    rack = 1'b0;
    forever begin
      @(re);
      if (ack_en) #(rdly);
      rack = ack_en && re;
    end
  end

  initial begin
    wack = 1'b0;
    forever begin
      @(we);
      if (ack_en) #(rdly);
      wack = ack_en && we;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!cmd_ready && k < 100) begin
      step();
      k++;
    end
    chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic run_cmd(input logic wen, input logic [4:0] rd,
                         input logic [31:0] wd, input logic [4:0] rs,
                         input logic [4:0] rt, input int hold,
                         input bit chk_lat);
    int          re0, we0, lat, nrd, nhs;
    logic [31:0] ers, ert, vrs, vrt;
    wait_ready();
    re0 = re_cnt;
    we0 = we_cnt;
    cmd_valid = 1'b1;
    cmd_wen   = wen;
    cmd_rd    = rd;
    cmd_wdata = wd;
    cmd_rs    = rs;
    cmd_rt    = rt;
    step();
    cmd_valid = 1'b0;
    chk("cmd_ready_drop", {31'd0, cmd_ready}, 32'd0);
    lat = 0;
    while (!rsp_valid && lat < 200) begin
      step();
      lat++;
    end
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    nrd = int'(rs != 5'd0) + int'(rt != 5'd0);
    nhs = nrd + int'(wen);
    // Each handshake costs four cycles with an immediate ack.
    if (chk_lat) chk("latency", lat, 4 * nhs);
    if (wen && rd != 5'd0) model[rd] = wd;
    ers = (rs == 5'd0) ? 32'd0 : model[rs];
    ert = (rt == 5'd0) ? 32'd0 : model[rt];
    vrs = rsp_rs_val;
    vrt = rsp_rt_val;
    chk("rs_val", vrs, ers);
    chk("rt_val", vrt, ert);
    chk("rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("re_pulses", re_cnt - re0, nrd);
    chk("we_pulses", we_cnt - we0, int'(wen));
    if (wen) begin
      chk("w_idx", {27'd0, we_idx_seen}, {27'd0, rd});
      chk("din", we_din_seen, wd);
    end
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_rs", rsp_rs_val, vrs);
      chk("hold_rt", rsp_rt_val, vrt);
      chk("hold_ready", {31'd0, cmd_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("consumed", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int          n;
    logic        w;
    logic [4:0]  a, b, c;
    cmd_valid = 1'b0;
    cmd_wen   = 1'b0;
    cmd_rs    = '0;
    cmd_rt    = '0;
    cmd_rd    = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;

    #2 rst = 1'b1;
    #1;
    chk("rst_re", {31'd0, re}, 32'd0);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_ridx", {27'd0, r_idx}, 32'd0);
    chk("rst_widx", {27'd0, w_idx}, 32'd0);
    chk("rst_din", din, 32'd0);
    chk("rst_rs_val", rsp_rs_val, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    for (int i = 1; i < 32; i++) run_cmd(1'b1, 5'(i), $urandom, 5'd0, 5'd0, 0, 1'b1);

    run_cmd(1'b1, 5'd5, 32'h1234, 5'd5, 5'd0, 0, 1'b1);
    run_cmd(1'b1, 5'd3, 32'd7, 5'd0, 5'd0, 0, 1'b1);
    run_cmd(1'b1, 5'd4, 32'd9, 5'd0, 5'd0, 0, 1'b1);
    run_cmd(1'b0, 5'd0, 32'd0, 5'd3, 5'd4, 10, 1'b1);
    run_cmd(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 0, 1'b1);
    run_cmd(1'b1, 5'd0, 32'hdead, 5'd0, 5'd0, 0, 1'b1);
    run_cmd(1'b0, 5'd0, 32'd0, 5'd0, 5'd4, 0, 1'b1);
    run_cmd(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 0, 1'b1);
    run_cmd(1'b1, 5'd7, 32'hcafe, 5'd3, 5'd7, 2, 1'b1);

    ack_en = 1'b0;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_wen   = 1'b0;
    cmd_rs    = 5'd3;
    cmd_rt    = 5'd4;
    step();
    cmd_valid = 1'b0;
    n = 0;
    while (re && n < 100) begin
      step();
      n++;
    end
    chk("timeout_re_len", n, 16);
    chk("timeout_err", {31'd0, rsp_err}, 32'd1);
    chk("timeout_valid", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("timeout_err_clr", {31'd0, rsp_err}, 32'd0);
    ack_en = 1'b1;
    run_cmd(1'b0, 5'd0, 32'd0, 5'd3, 5'd4, 0, 1'b1);

    ack_en = 1'b0;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_rs    = 5'd5;
    cmd_rt    = 5'd6;
    step();
    cmd_valid = 1'b0;
    repeat (3) step();
    chk("r1_req_re", {31'd0, re}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_re", {31'd0, re}, 32'd0);
    chk("midrst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_ready", {31'd0, cmd_ready}, 32'd0);
    step();
    rst    = 1'b0;
    ack_en = 1'b1;
    run_cmd(1'b0, 5'd0, 32'd0, 5'd5, 5'd6, 0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      rdly = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 23));
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      b = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      c = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      run_cmd(w, a, $urandom, b, c, int'($urandom_range(0, 3)), rdly == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
